// File: rtl/sum_stationary_pkg.sv
// Purpose: shared defaults, result-width helper and block state type for sum_stationary.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_stationary_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_N          = 4;

    // Block phase: collecting N beats, or waiting for the wavefront to reach PE(N-1,N-1).
    typedef enum logic {
        ACCEPT = 1'b0,
        DRAIN  = 1'b1
    } state_e;

    // Full product width plus enough headroom to sum N products without wrapping.
    function automatic int c_data_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

endpackage

// File: rtl/sum_stationary_pe.sv
// Purpose: one multiply-accumulate cell; forwards A right and B down through registers.
// Latency: 1 cycle operand forwarding; the accumulator updates on the edge its operands arrive.
// Backpressure: none; the cell updates whenever a valid tag reaches it.
// Ports: a_*/b_* inputs (data, valid tag, first-beat tag), a_*_o/b_*_o registered
//        copies for the neighbouring cells, acc_o accumulator value.
module sum_stationary_pe #(
    parameter int DATA_WIDTH   = 8,
    parameter int C_DATA_WIDTH = 18
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic                    a_vld_i,
    input  logic                    a_fst_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic                    b_vld_i,
    input  logic                    b_fst_i,
    output logic [DATA_WIDTH-1:0]   a_o,
    output logic                    a_vld_o,
    output logic                    a_fst_o,
    output logic [DATA_WIDTH-1:0]   b_o,
    output logic                    b_vld_o,
    output logic                    b_fst_o,
    output logic [C_DATA_WIDTH-1:0] acc_o
);

    logic [2*DATA_WIDTH-1:0]  prod;
    logic [C_DATA_WIDTH-1:0]  prod_ext;
    logic [C_DATA_WIDTH-1:0]  acc_q, acc_d;

    assign prod     = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    assign prod_ext = C_DATA_WIDTH'(prod);

    // A and B of the same beat always meet here on the same edge, so the tags agree;
    // requiring both keeps a stray tag on either path from corrupting the sum.
    always_comb begin
        acc_d = acc_q;
        if (a_vld_i && b_vld_i) begin
            acc_d = a_fst_i ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q   <= '0;
            a_o     <= '0;
            a_vld_o <= 1'b0;
            a_fst_o <= 1'b0;
            b_o     <= '0;
            b_vld_o <= 1'b0;
            b_fst_o <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            a_o     <= a_i;
            a_vld_o <= a_vld_i;
            a_fst_o <= a_fst_i;
            b_o     <= b_i;
            b_vld_o <= b_vld_i;
            b_fst_o <= b_fst_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sum_stationary.sv
// Purpose: N x N output-stationary systolic matrix multiply, C = A*B, one A column + B row per beat.
// Latency: valid_o rises 2N-2 cycles after the edge accepting the N-th beat (same edge when N=1).
// Backpressure: none; beats offered during DRAIN are dropped, idle cycles between beats are allowed.
// Ports: clk_i, reset_i (async, active low), valid_i/a_i/b_i beat input,
//        valid_o one-cycle completion pulse, c_o row-major accumulators.
module sum_stationary
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int N            = DEF_N,
    parameter int C_DATA_WIDTH = c_data_width(DATA_WIDTH, N)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   a_i [N],
    input  logic [DATA_WIDTH-1:0]   b_i [N],
    output logic                    valid_o,
    output logic [C_DATA_WIDTH-1:0] c_o [N*N]
);

    localparam int BCW        = (N > 1) ? $clog2(N) : 1;
    localparam int DCW        = (N > 1) ? $clog2(2 * N - 2) : 1;
    localparam int DRAIN_LAST = (N > 1) ? 2 * N - 3 : 0;

    state_e             state_q, state_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
    logic               valid_q, valid_d;
    logic               accept;
    logic               first;

    assign accept = valid_i && (state_q == ACCEPT);
    assign first  = (beat_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        valid_d     = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (valid_i) begin
                    if (beat_cnt_q == BCW'(N - 1)) begin
                        beat_cnt_d = '0;
                        if (N == 1) begin
                            valid_d = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            DRAIN: begin
                // The final drain edge is the one on which PE(N-1,N-1) takes the last beat.
                if (drain_cnt_q == DCW'(DRAIN_LAST)) begin
                    state_d     = ACCEPT;
                    drain_cnt_d = '0;
                    valid_d     = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ACCEPT;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign valid_o = valid_q;

    // Edge feeds: row i of A / column j of B delayed by i / j cycles, tags travelling alongside.
    logic [DATA_WIDTH-1:0] a_row     [N];
    logic                  a_row_vld [N];
    logic                  a_row_fst [N];
    logic [DATA_WIDTH-1:0] b_col     [N];
    logic                  b_col_vld [N];
    logic                  b_col_fst [N];

    for (genvar l = 0; l < N; l++) begin : g_skew
        if (l == 0) begin : g_direct
            assign a_row[l]     = a_i[l];
            assign a_row_vld[l] = accept;
            assign a_row_fst[l] = first;
            assign b_col[l]     = b_i[l];
            assign b_col_vld[l] = accept;
            assign b_col_fst[l] = first;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] a_sr_q [l];
            logic [DATA_WIDTH-1:0] b_sr_q [l];
            logic                  v_sr_q [l];
            logic                  f_sr_q [l];

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    for (int s = 0; s < l; s++) begin
                        a_sr_q[s] <= '0;
                        b_sr_q[s] <= '0;
                        v_sr_q[s] <= 1'b0;
                        f_sr_q[s] <= 1'b0;
                    end
                end else begin
                    a_sr_q[0] <= a_i[l];
                    b_sr_q[0] <= b_i[l];
                    v_sr_q[0] <= accept;
                    f_sr_q[0] <= first;
                    for (int s = 1; s < l; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                        v_sr_q[s] <= v_sr_q[s-1];
                        f_sr_q[s] <= f_sr_q[s-1];
                    end
                end
            end

            assign a_row[l]     = a_sr_q[l-1];
            assign a_row_vld[l] = v_sr_q[l-1];
            assign a_row_fst[l] = f_sr_q[l-1];
            assign b_col[l]     = b_sr_q[l-1];
            assign b_col_vld[l] = v_sr_q[l-1];
            assign b_col_fst[l] = f_sr_q[l-1];
        end
    end

    // Registered outputs of every PE, indexed row-major like c_o.
    logic [DATA_WIDTH-1:0] a_fwd     [N*N];
    logic                  a_fwd_vld [N*N];
    logic                  a_fwd_fst [N*N];
    logic [DATA_WIDTH-1:0] b_fwd     [N*N];
    logic                  b_fwd_vld [N*N];
    logic                  b_fwd_fst [N*N];

    for (genvar i = 0; i < N; i++) begin : g_r
        for (genvar j = 0; j < N; j++) begin : g_c
            logic [DATA_WIDTH-1:0] a_in, b_in;
            logic                  a_in_vld, a_in_fst, b_in_vld, b_in_fst;

            if (j == 0) begin : g_a_edge
                assign a_in     = a_row[i];
                assign a_in_vld = a_row_vld[i];
                assign a_in_fst = a_row_fst[i];
            end else begin : g_a_left
                assign a_in     = a_fwd[i*N+j-1];
                assign a_in_vld = a_fwd_vld[i*N+j-1];
                assign a_in_fst = a_fwd_fst[i*N+j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in     = b_col[j];
                assign b_in_vld = b_col_vld[j];
                assign b_in_fst = b_col_fst[j];
            end else begin : g_b_up
                assign b_in     = b_fwd[(i-1)*N+j];
                assign b_in_vld = b_fwd_vld[(i-1)*N+j];
                assign b_in_fst = b_fwd_fst[(i-1)*N+j];
            end

            sum_stationary_pe #(
                .DATA_WIDTH   (DATA_WIDTH),
                .C_DATA_WIDTH (C_DATA_WIDTH)
            ) u_pe (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .a_i     (a_in),
                .a_vld_i (a_in_vld),
                .a_fst_i (a_in_fst),
                .b_i     (b_in),
                .b_vld_i (b_in_vld),
                .b_fst_i (b_in_fst),
                .a_o     (a_fwd[i*N+j]),
                .a_vld_o (a_fwd_vld[i*N+j]),
                .a_fst_o (a_fwd_fst[i*N+j]),
                .b_o     (b_fwd[i*N+j]),
                .b_vld_o (b_fwd_vld[i*N+j]),
                .b_fst_o (b_fwd_fst[i*N+j]),
                .acc_o   (c_o[i*N+j])
            );
        end
    end

endmodule

// File: tb/tb_sum_stationary.sv
module tb_sum_stationary;

    localparam int DW = 8;
    localparam int NN = 4;
    localparam int CW = 18;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic [DW-1:0] a_i [NN];
    logic [DW-1:0] b_i [NN];
    logic          valid_o;
    logic [CW-1:0] c_o [NN*NN];

    int vectors     = 0;
    int miscompares = 0;

    // Current block operands: A[k][i] = A(i,k) (column beat k), B[k][j] = B(k,j) (row beat k).
    logic [DW-1:0] A [NN][NN];
    logic [DW-1:0] B [NN][NN];

    always #5 clk_i = ~clk_i;

    sum_stationary dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .c_o     (c_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0;
        for (int i = 0; i < NN; i++) begin
            a_i[i] = 'x;
            b_i[i] = 'x;
        end
    endtask

    task automatic random_inputs(input logic v);
        valid_i = v;
        for (int i = 0; i < NN; i++) begin
            a_i[i] = DW'($urandom);
            b_i[i] = DW'($urandom);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NN; k++)
            for (int i = 0; i < NN; i++) begin
                A[k][i] = DW'($urandom);
                B[k][i] = DW'($urandom);
            end
    endtask

    // Dot product of row i of A with column j of B, reduced modulo 2^CW.
    function automatic logic [CW-1:0] ref_c(input int i, input int j);
        longint s;
        s = 0;
        for (int k = 0; k < NN; k++) s += longint'(A[k][i]) * longint'(B[k][j]);
        return s[CW-1:0];
    endfunction

    // Sends the current A/B block with up to gap_max idle cycles before each beat, then watches
    // the drain for the single completion pulse 6 cycles after the last beat and checks c_o.
    task automatic send_block(input string name, input int gap_max, input bit hold, input bit rst_at_pulse);
        int lat;
        int pulses;
        for (int k = 0; k < NN; k++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                idle_inputs();
                step();
            end
            valid_i = 1'b1;
            for (int i = 0; i < NN; i++) begin
                a_i[i] = A[k][i];
                b_i[i] = B[k][i];
            end
            step();
        end
        lat    = -1;
        pulses = 0;
        for (int d = 1; d <= 10; d++) begin
            if (hold && d <= 6) random_inputs(1'b1);
            else idle_inputs();
            step();
            if (valid_o === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = d;
                    for (int e = 0; e < NN*NN; e++) begin
                        vectors++;
                        if (c_o[e] !== ref_c(e / NN, e % NN)) begin
                            miscompares++;
                            $display("FAIL %s c_o[%0d]: got %0d expected %0d", name, e, c_o[e], ref_c(e / NN, e % NN));
                        end
                    end
                    if (rst_at_pulse) begin
                        reset_i = 1'b0;
                        #1;
                        vectors++;
                        if (valid_o !== 1'b0) begin
                            miscompares++;
                            $display("FAIL %s valid_o under reset: got %b expected 0", name, valid_o);
                        end
                        vectors++;
                        if (c_o[NN*NN-1] !== '0) begin
                            miscompares++;
                            $display("FAIL %s c_o[15] under reset: got %0d expected 0", name, c_o[NN*NN-1]);
                        end
                        reset_i = 1'b1;
                    end
                end
            end
        end
        vectors++;
        if (lat != 6) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected 6", name, lat);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL %s pulse count: got %0d expected 1", name, pulses);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        random_inputs(1'b1);
        step();
        random_inputs(1'b1);
        step();
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset valid_o: got %b expected 0", valid_o);
        end
        idle_inputs();
        reset_i = 1'b1;
        step();
        for (int e = 0; e < NN*NN; e++) begin
            vectors++;
            if (c_o[e] !== '0) begin
                miscompares++;
                $display("FAIL reset c_o[%0d]: got %0d expected 0", e, c_o[e]);
            end
        end
    endtask

    task automatic load_pattern();
        for (int k = 0; k < NN; k++)
            for (int i = 0; i < NN; i++) begin
                A[k][i] = DW'(4 * k + i + 1);
                B[k][i] = DW'(8'h11 + 4 * k + i);
            end
    endtask

    task automatic test_contiguous();
        load_pattern();
        send_block("contig", 0, 1'b0, 1'b0);
        vectors++;
        if (c_o[0] !== 18'd724) begin
            miscompares++;
            $display("FAIL contig C00: got %0d expected 724", c_o[0]);
        end
        vectors++;
        if (c_o[15] !== 18'd1120) begin
            miscompares++;
            $display("FAIL contig C33: got %0d expected 1120", c_o[15]);
        end
    endtask

    task automatic test_gaps();
        load_pattern();
        send_block("gaps", 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_random();
        send_block("b2b_first", 0, 1'b1, 1'b0);
        fill_random();
        send_block("b2b_second", 0, 1'b1, 1'b0);
    endtask

    task automatic test_max();
        for (int k = 0; k < NN; k++)
            for (int i = 0; i < NN; i++) begin
                A[k][i] = 8'hFF;
                B[k][i] = 8'hFF;
            end
        send_block("max", 1, 1'b0, 1'b0);
        // Accumulators must still hold the finished block well after the pulse.
        for (int e = 0; e < NN*NN; e++) begin
            vectors++;
            if (c_o[e] !== 18'd260100) begin
                miscompares++;
                $display("FAIL max hold c_o[%0d]: got %0d expected 260100", e, c_o[e]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            random_inputs(1'b1);
            step();
        end
        idle_inputs();
        reset_i = 1'b0;
        step();
        vectors++;
        if (c_o[0] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid c_o[0]: got %0d expected 0", c_o[0]);
        end
        reset_i = 1'b1;
        fill_random();
        send_block("reset_mid", 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_at_pulse();
        fill_random();
        send_block("rst_pulse", 0, 1'b0, 1'b1);
        fill_random();
        send_block("after_rst_pulse", 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            fill_random();
            send_block("random", $urandom_range(2, 0), 1'($urandom_range(1, 0)), 1'b0);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_contiguous();
        test_gaps();
        test_back_to_back();
        test_max();
        test_reset_mid();
        test_reset_at_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
